// File: rtl/lfsr_misr_bist.sv
// Galois LFSR/MISR BIST engine: pattern generation or response compaction,
// run control by pattern count, and a one-cycle signature compare.
module lfsr_misr_bist #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h0040_0007),
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  input  logic [CNT_W-1:0] pattern_count,
  input  logic [WIDTH-1:0] golden,
  input  logic [1:0]       weight_sel,
  output logic [WIDTH-1:0] pattern_out,
  output logic [WIDTH-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_s, w_s_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [CNT_W-1:0] r_pc, w_pc_next;
  logic             r_misr, w_misr_next;
  logic             r_pass, w_pass_next;

  logic [WIDTH-1:0] w_step_val;
  logic [WIDTH-1:0] w_seed_val;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_step_en;
  logic [WIDTH-1:0] w_rot1, w_rot2;

  assign w_step_val = {r_s[WIDTH-2:0], 1'b0}
                    ^ (r_s[WIDTH-1] ? POLY : '0)
                    ^ (r_misr ? data_in : '0);
  // The register must never lock up at zero, so a zero seed becomes 1.
  assign w_seed_val = (seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_step_en  = !r_misr || data_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= {{(WIDTH-1){1'b0}}, 1'b1};
      r_cnt   <= '0;
      r_pc    <= '0;
      r_misr  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_cnt   <= w_cnt_next;
      r_pc    <= w_pc_next;
      r_misr  <= w_misr_next;
      r_pass  <= w_pass_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_cnt_next   = r_cnt;
    w_pc_next    = r_pc;
    w_misr_next  = r_misr;
    w_pass_next  = r_pass;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (seed_load) begin
          w_s_next     = w_seed_val;
          w_pass_next  = 1'b0;
          w_state_next = ST_IDLE;
        end
        // Start after the seed update so a same-cycle load seeds the run.
        if (start) begin
          w_cnt_next   = '0;
          w_pc_next    = pattern_count;
          w_misr_next  = (mode == 2'b01);
          w_pass_next  = 1'b0;
          w_state_next = (pattern_count == '0) ? ST_CHECK : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (w_step_en) begin
          w_s_next   = w_step_val;
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == r_pc) begin
            w_state_next = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        w_pass_next  = (r_s == golden);
        w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_rot1 = {r_s[WIDTH-2:0], r_s[WIDTH-1]};
  assign w_rot2 = {r_s[WIDTH-3:0], r_s[WIDTH-1:WIDTH-2]};

  always_comb begin
    pattern_out = r_s;
    case (weight_sel)
      2'b00:   pattern_out = r_s;
      2'b01:   pattern_out = r_s & w_rot1;
      2'b10:   pattern_out = ~(r_s & w_rot1);
      default: pattern_out = r_s & w_rot1 & w_rot2;
    endcase
  end

  assign signature = r_s;
  assign busy      = (r_state == ST_RUN) || (r_state == ST_CHECK);
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;

endmodule

// File: tb/tb_lfsr_misr_bist.sv
// Directed bench for lfsr_misr_bist: table-driven runs and weight vectors,
// plus hand-written MISR, abort, reset and DONE-hold sequences.
module tb_lfsr_misr_bist;

  logic        clk = 1'b0;
  logic        rst, start, abort, seed_load, data_valid;
  logic [1:0]  mode, weight_sel;
  logic [31:0] seed, data_in, golden, pattern_out, signature;
  logic [15:0] pattern_count;
  logic        busy, done, pass;

  int n_checks = 0;
  int n_fail   = 0;

  lfsr_misr_bist dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .seed_load(seed_load), .seed(seed), .data_in(data_in),
    .data_valid(data_valid), .pattern_count(pattern_count), .golden(golden),
    .weight_sel(weight_sel), .pattern_out(pattern_out), .signature(signature),
    .busy(busy), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] seed;
    logic [15:0] pc;
    logic [31:0] golden;
    logic [31:0] exp_sig;
    logic        exp_pass;
  } run_vec_t;

  typedef struct {
    logic [31:0] s;
    logic [1:0]  wsel;
    logic [31:0] exp_pat;
  } wvec_t;

  run_vec_t runs [6];
  wvec_t    wvecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  int cyc;

  initial begin
    runs[0] = '{2'b00, 32'h0000_0001, 16'd1,  32'h0000_0002, 32'h0000_0002, 1'b1};
    runs[1] = '{2'b00, 32'h0000_0001, 16'd32, 32'h0040_0007, 32'h0040_0007, 1'b1};
    runs[2] = '{2'b00, 32'h0000_0000, 16'd0,  32'h0000_0001, 32'h0000_0001, 1'b1};
    runs[3] = '{2'b00, 32'h8000_0000, 16'd1,  32'h0000_0000, 32'h0040_0007, 1'b0};
    runs[4] = '{2'b10, 32'h0000_0003, 16'd4,  32'h0000_0030, 32'h0000_0030, 1'b1};
    runs[5] = '{2'b11, 32'hC000_0000, 16'd2,  32'h00C0_0009, 32'h00C0_0009, 1'b1};

    wvecs[0] = '{32'h8000_0001, 2'b00, 32'h8000_0001};
    wvecs[1] = '{32'h8000_0001, 2'b01, 32'h0000_0001};
    wvecs[2] = '{32'h8000_0001, 2'b10, 32'hFFFF_FFFE};
    wvecs[3] = '{32'h8000_0001, 2'b11, 32'h0000_0000};
    wvecs[4] = '{32'hF0F0_F0F0, 2'b00, 32'hF0F0_F0F0};
    wvecs[5] = '{32'hF0F0_F0F0, 2'b01, 32'hE0E0_E0E0};
    wvecs[6] = '{32'hF0F0_F0F0, 2'b10, 32'h1F1F_1F1F};
    wvecs[7] = '{32'hF0F0_F0F0, 2'b11, 32'hC0C0_C0C0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; seed_load = 1'b0; data_valid = 1'b0;
    mode = 2'b00; weight_sel = 2'b00; seed = '0; data_in = '0; golden = '0;
    pattern_count = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_sig",  signature, 32'h1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    $display("reset: sig=0x%08h busy=%0b done=%0b pass=%0b", signature, busy, done, pass);

    // PRPG, one pattern, straight out of reset: RUN, CHECK, DONE
    mode = 2'b00; pattern_count = 16'd1; golden = 32'h2; start = 1'b1;
    tick(); start = 1'b0;
    check("p1_busy_run", busy, 1);
    tick();
    check("p1_sig_check", signature, 32'h2);
    check("p1_busy_check", busy, 1);
    check("p1_done_check", done, 0);
    tick();
    check("p1_done", done, 1);
    check("p1_busy_done", busy, 0);
    check("p1_pass", pass, 1);
    $display("prpg pc=1: sig=0x%08h done=%0b pass=%0b", signature, done, pass);

    // table of runs, each seeded by a same-cycle seed_load + start
    for (int i = 0; i < 6; i++) begin
      mode = runs[i].mode; seed = runs[i].seed; pattern_count = runs[i].pc;
      golden = runs[i].golden; seed_load = 1'b1; start = 1'b1;
      tick();
      seed_load = 1'b0; start = 1'b0;
      wait_done(cyc);
      check($sformatf("run%0d_latency", i), cyc, runs[i].pc + 1);
      check($sformatf("run%0d_sig", i), signature, runs[i].exp_sig);
      check($sformatf("run%0d_pass", i), pass, runs[i].exp_pass);
      $display("run %0d: mode=%0d seed=0x%08h pc=%0d sig=0x%08h pass=%0b cycles=%0d",
               i, runs[i].mode, runs[i].seed, runs[i].pc, signature, pass, cyc);
    end

    // DONE holds, then seed_load with zero seed returns to IDLE with S=1
    tick(); tick(); tick();
    check("hold_done", done, 1);
    check("hold_sig", signature, 32'h00C0_0009);
    check("hold_pass", pass, 1);
    seed = 32'h0; seed_load = 1'b1;
    tick(); seed_load = 1'b0;
    check("reload_done", done, 0);
    check("reload_pass", pass, 0);
    check("reload_sig", signature, 32'h1);
    $display("done hold + reload: sig=0x%08h done=%0b pass=%0b", signature, done, pass);

    // MISR: three idle RUN cycles (mode change ignored), then one valid word
    mode = 2'b01; pattern_count = 16'd1; golden = 32'h13; data_in = 32'h10;
    start = 1'b1;
    tick(); start = 1'b0; mode = 2'b00;
    for (int k = 0; k < 3; k++) tick();
    check("misr_idle_sig", signature, 32'h1);
    check("misr_idle_busy", busy, 1);
    data_valid = 1'b1;
    tick(); data_valid = 1'b0;
    check("misr_sig", signature, 32'h12);
    tick();
    check("misr_done", done, 1);
    check("misr_pass", pass, 0);
    $display("misr: sig=0x%08h done=%0b pass=%0b", signature, done, pass);

    // abort after 5 steps; start/seed_load during RUN ignored
    mode = 2'b00; seed = 32'h1; pattern_count = 16'd10; seed_load = 1'b1; start = 1'b1;
    tick(); seed_load = 1'b0; start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin start = 1'b1; seed_load = 1'b1; seed = 32'h55; end
      tick();
      start = 1'b0; seed_load = 1'b0;
    end
    abort = 1'b1;
    tick(); abort = 1'b0;
    check("abort_sig", signature, 32'h20);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    tick(); tick();
    check("abort_hold_sig", signature, 32'h20);
    check("abort_hold_done", done, 0);
    check("abort_pass", pass, 0);
    $display("abort: sig=0x%08h busy=%0b done=%0b", signature, busy, done);

    // abort wins over the terminal step
    seed = 32'h1; pattern_count = 16'd3; seed_load = 1'b1; start = 1'b1;
    tick(); seed_load = 1'b0; start = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick(); abort = 1'b0;
    check("abort_term_sig", signature, 32'h4);
    check("abort_term_busy", busy, 0);
    tick();
    check("abort_term_done", done, 0);
    $display("abort vs terminal: sig=0x%08h done=%0b", signature, done);

    // reset mid-run discards the run
    seed = 32'h7; pattern_count = 16'd20; seed_load = 1'b1; start = 1'b1;
    tick(); seed_load = 1'b0; start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    check("midrst_sig", signature, 32'h1);
    check("midrst_busy", busy, 0);
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done) break;
    end
    check("midrst_done", done, 0);
    $display("mid-run reset: sig=0x%08h busy=%0b done=%0b", signature, busy, done);

    // pattern weighting table
    for (int i = 0; i < 8; i++) begin
      seed = wvecs[i].s; seed_load = 1'b1;
      tick(); seed_load = 1'b0;
      weight_sel = wvecs[i].wsel;
      #1;
      check($sformatf("weight%0d", i), pattern_out, wvecs[i].exp_pat);
      $display("weight %0d: S=0x%08h sel=%0d pattern=0x%08h", i, signature, weight_sel, pattern_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_misr_bist.md
LFSR_MISR_BIST -- requirements
Module: lfsr_misr_bist

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WIDTH, 32, signature/pattern register width (8..64).
- POLY, 32'h0040_0007, Galois feedback mask (bit i set = tap into bit i); default is x^32+x^22+x^2+x+1.
- CNT_W, 16, pattern-counter width.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a run; honoured only in IDLE or DONE.
- abort  in  1  terminate a run; honoured only in RUN.
- mode  in  2  run mode: 00 PRPG, 01 MISR, 10/11 reserved and treated as PRPG.
- seed_load  in  1  load seed into the signature register; honoured only in IDLE or DONE.
- seed  in  WIDTH  seed value.
- data_in  in  WIDTH  response word to compact.
- data_valid  in  1  data_in qualifier.
- pattern_count  in  CNT_W  number of register advances per run.
- golden  in  WIDTH  expected signature.
- weight_sel  in  2  pattern weighting select.
- pattern_out  out  WIDTH  weighted pattern.
- signature  out  WIDTH  current register value.
- busy  out  1  high in RUN and CHECK.
- done  out  1  high in DONE.
- pass  out  1  compare result; valid while done is high.

Function
REQ-003 The block SHALL hold one WIDTH-bit register S; signature SHALL equal S combinationally.
REQ-004 Step function: next = {S[WIDTH-2:0],1'b0} ^ (S[WIDTH-1] ? POLY[WIDTH-1:0] : 0) ^ (mode==01 ? data_in : 0).
REQ-005 The FSM SHALL have states IDLE, RUN, CHECK, DONE, encoded in 2 bits.
REQ-006 IDLE or DONE with start=1 SHALL clear the counter and move to RUN next cycle; pattern_count==0 SHALL instead move directly to CHECK.
REQ-007 In RUN with mode PRPG, S SHALL step every cycle. In RUN with mode MISR, S SHALL step only in cycles with data_valid=1 and SHALL hold otherwise.
REQ-008 The counter SHALL increment on each step. The step that brings the counter to pattern_count SHALL also move the FSM to CHECK.
REQ-009 CHECK SHALL last exactly one cycle; it SHALL register pass = (S==golden) and move to DONE.
REQ-010 DONE SHALL hold S, pass and done until start (REQ-006) or seed_load is seen.
- seed_load in DONE SHALL return the FSM to IDLE and clear pass.
REQ-011 seed_load SHALL set S = (seed==0) ? 1 : seed; an all-zero seed is never loaded.
- seed_load together with start in the same cycle: the seed SHALL be loaded first, and the run SHALL begin from that seed.
REQ-012 seed_load, start and mode changes in RUN or CHECK SHALL be ignored. mode SHALL be sampled at start and held for the run.
REQ-013 abort in RUN SHALL move to IDLE next cycle; S SHALL keep its value and pass SHALL stay 0. abort has priority over a terminal step in the same cycle.
REQ-014 The counter SHALL be CNT_W bits and SHALL never wrap within a run; the maximum run length is 2^CNT_W-1 steps.
REQ-015 pattern_out SHALL be combinational. With R1 = S rotated left by 1 and R2 = S rotated left by 2:
- weight_sel 00: S (p=1/2).
- weight_sel 01: S&R1 (p=1/4).
- weight_sel 10: ~(S&R1) (p=3/4).
- weight_sel 11: S&R1&R2 (p=1/8).
REQ-016 busy SHALL rise the cycle after an accepted start and fall on entry to DONE or IDLE.

Reset
REQ-017 rst=1 at a clock edge SHALL force, from any state and overriding all other inputs:
- FSM = IDLE.
- S = 1.
- counter = 0.
- pass = 0, busy = 0, done = 0.
REQ-018 Reset asserted mid-run SHALL discard the run, with no CHECK and no done pulse.

Verification
REQ-019 Reset, then PRPG start with pattern_count=1 -> S=0x0000_0002; one cycle in CHECK; done=1.
REQ-020 PRPG run from seed 1 with pattern_count=32 -> S=0x0040_0007 at DONE; golden=0x0040_0007 gives pass=1.
REQ-021 MISR run: seed 1, pattern_count=1, data_valid pulsed once with data_in=0x0000_0010 after 3 idle RUN cycles -> S=0x0000_0012; with golden=0x13, pass=0.
REQ-022 seed_load with seed=0 -> S=1. Then start with pattern_count=0 -> CHECK on the next cycle, then DONE; S stays 1.
REQ-023 abort at the 5th RUN cycle of a pattern_count=10 run -> IDLE; done=0; S holds the 5-step value; start/seed_load pulses during RUN have no effect.
REQ-024 S=0x8000_0001 with each weight_sel -> pattern_out:
- 00: 0x8000_0001.
- 01: 0x0000_0001.
- 10: 0xFFFF_FFFE.
- 11: 0x0000_0000.
